// File: rtl/writeback_queue.sv
// Writeback queue: buffers ALU/load results and drains one register-file write per cycle.
// Queued destinations are visible to the bypass lookup until they retire.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aluValid,
  input  logic [4:0]               aluRd,
  input  logic [XLEN-1:0]          aluData,
  output logic                     aluReady,
  input  logic                     memValid,
  input  logic [4:0]               memRd,
  input  logic [XLEN-1:0]          memData,
  output logic                     memReady,
  output logic                     rfWriteEnable,
  output logic [4:0]               rfRd,
  output logic [XLEN-1:0]          rfData,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     rs1Hit,
  output logic                     rs2Hit,
  output logic [XLEN-1:0]          rs1Fwd,
  output logic [XLEN-1:0]          rs2Fwd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   head_r;
  logic [AW-1:0]   tail_r;
  logic [AW:0]     count_r;
  logic [4:0]      rd_r   [DEPTH];
  logic [XLEN-1:0] data_r [DEPTH];

  logic            full_s;
  logic            empty_s;
  logic            mem_ready_s;
  logic            alu_ready_s;
  logic            push_s;
  logic            pop_s;
  logic [4:0]      push_rd_s;
  logic [XLEN-1:0] push_data_s;

  // Handshake arbitration: the load port always wins; x0 writes are acknowledged but dropped.
  always_comb begin
    full_s      = (count_r == (AW+1)'(DEPTH));
    empty_s     = (count_r == (AW+1)'(0));
    mem_ready_s = !full_s && !rst;
    alu_ready_s = !full_s && !memValid && !rst;
    push_rd_s   = 5'd0;
    push_data_s = {XLEN{1'b0}};
    if (memValid && mem_ready_s) begin
      push_rd_s   = memRd;
      push_data_s = memData;
    end else if (aluValid && alu_ready_s) begin
      push_rd_s   = aluRd;
      push_data_s = aluData;
    end else begin
      push_rd_s   = 5'd0;
      push_data_s = {XLEN{1'b0}};
    end
    push_s = (push_rd_s != 5'd0);
    pop_s  = !empty_s;
  end

  // Pointer and occupancy bookkeeping; power-of-two depth makes the pointers wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + AW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      count_r <= count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end
  end

  // Entry storage; contents only matter while occupied, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      rd_r[tail_r]   <= push_rd_s;
      data_r[tail_r] <= push_data_s;
    end
  end

  logic [AW-1:0]   idx_s;
  logic            occ_s;
  logic            m1_s;
  logic            m2_s;
  logic            rs1_hit_s;
  logic            rs2_hit_s;
  logic [XLEN-1:0] rs1_fwd_s;
  logic [XLEN-1:0] rs2_fwd_s;

  // Bypass lookup: walk oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    rs1_fwd_s = {XLEN{1'b0}};
    rs2_fwd_s = {XLEN{1'b0}};
    idx_s     = {AW{1'b0}};
    occ_s     = 1'b0;
    m1_s      = 1'b0;
    m2_s      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s     = head_r + AW'(k);
      occ_s     = ((AW+1)'(k) < count_r) && !rst;
      m1_s      = occ_s && (rs1 != 5'd0) && (rd_r[idx_s] == rs1);
      m2_s      = occ_s && (rs2 != 5'd0) && (rd_r[idx_s] == rs2);
      rs1_hit_s = rs1_hit_s | m1_s;
      rs2_hit_s = rs2_hit_s | m2_s;
      rs1_fwd_s = m1_s ? data_r[idx_s] : rs1_fwd_s;
      rs2_fwd_s = m2_s ? data_r[idx_s] : rs2_fwd_s;
    end
  end

  // Register-file port and status, all forced quiet while reset is asserted.
  always_comb begin
    rfWriteEnable = !empty_s && !rst;
    rfRd          = rfWriteEnable ? rd_r[head_r]   : 5'd0;
    rfData        = rfWriteEnable ? data_r[head_r] : {XLEN{1'b0}};
    aluReady      = alu_ready_s;
    memReady      = mem_ready_s;
    rs1Hit        = rs1_hit_s;
    rs2Hit        = rs2_hit_s;
    rs1Fwd        = rs1_fwd_s;
    rs2Fwd        = rs2_fwd_s;
    count         = count_r;
    full          = full_s && !rst;
    empty         = empty_s || rst;
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios followed by random traffic, all
// compared each cycle against a queue-based reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            aluValid, memValid;
  logic [4:0]      aluRd, memRd, rs1, rs2;
  logic [XLEN-1:0] aluData, memData;
  logic            aluReady, memReady, rfWriteEnable, rs1Hit, rs2Hit, full, empty;
  logic [4:0]      rfRd;
  logic [XLEN-1:0] rfData, rs1Fwd, rs2Fwd;
  logic [$clog2(DEPTH):0] count;

  int compared   = 0;
  int mismatched = 0;

  logic [4:0]      mq_rd[$];
  logic [XLEN-1:0] mq_data[$];
  logic [4:0]      write_log[$];

  writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memRd(memRd), .memData(memData), .memReady(memReady),
    .rfWriteEnable(rfWriteEnable), .rfRd(rfRd), .rfData(rfData),
    .rs1(rs1), .rs2(rs2), .rs1Hit(rs1Hit), .rs2Hit(rs2Hit),
    .rs1Fwd(rs1Fwd), .rs2Fwd(rs2Fwd),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model, then advance one clock and update the model.
  task automatic step();
    int n;
    logic mhs, ahs, h1, h2;
    logic [XLEN-1:0] f1, f2;
    #1;
    n  = mq_rd.size();
    h1 = 1'b0; h2 = 1'b0; f1 = '0; f2 = '0;
    if (!rst) begin
      for (int k = 0; k < n; k++) begin
        if (rs1 != 5'd0 && mq_rd[k] == rs1) begin h1 = 1'b1; f1 = mq_data[k]; end
        if (rs2 != 5'd0 && mq_rd[k] == rs2) begin h2 = 1'b1; f2 = mq_data[k]; end
      end
    end
    chk("count",    count, n);
    chk("empty",    empty, (n == 0) || rst);
    chk("full",     full, (n == DEPTH) && !rst);
    chk("memReady", memReady, (n < DEPTH) && !rst);
    chk("aluReady", aluReady, (n < DEPTH) && !memValid && !rst);
    chk("rfWE",     rfWriteEnable, (n > 0) && !rst);
    chk("rfRd",     rfRd, (n > 0 && !rst) ? mq_rd[0] : 5'd0);
    chk("rfData",   rfData, (n > 0 && !rst) ? mq_data[0] : 32'd0);
    chk("rs1Hit",   rs1Hit, h1);
    chk("rs1Fwd",   rs1Fwd, f1);
    chk("rs2Hit",   rs2Hit, h2);
    chk("rs2Fwd",   rs2Fwd, f2);
    mhs = memValid && (n < DEPTH) && !rst;
    ahs = aluValid && (n < DEPTH) && !memValid && !rst;
    @(posedge clk);
    if (rst) begin
      mq_rd.delete();
      mq_data.delete();
    end else begin
      if (n > 0) begin
        write_log.push_back(mq_rd[0]);
        void'(mq_rd.pop_front());
        void'(mq_data.pop_front());
      end
      if (mhs) begin
        if (memRd != 5'd0) begin mq_rd.push_back(memRd); mq_data.push_back(memData); end
      end else if (ahs) begin
        if (aluRd != 5'd0) begin mq_rd.push_back(aluRd); mq_data.push_back(aluData); end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; aluValid = 1'b0; memValid = 1'b0;
    aluRd = 5'd0; memRd = 5'd0; aluData = '0; memData = '0; rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    #1 chk("rst_release_empty", empty, 1'b1);
    step();

    // Single write and bypass of it
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF; rs1 = 5'd5;
    step();
    aluValid = 1'b0;
    #1;
    chk("single_we", rfWriteEnable, 1'b1);
    chk("single_rd", rfRd, 5'd5);
    chk("single_data", rfData, 32'hDEADBEEF);
    chk("single_hit", rs1Hit, 1'b1);
    chk("single_fwd", rs1Fwd, 32'hDEADBEEF);
    step();
    #1 chk("single_drained", empty, 1'b1);
    step();

    // Arbitration: load port wins, held ALU request lands next cycle
    memValid = 1'b1; memRd = 5'd3; memData = 32'h33;
    aluValid = 1'b1; aluRd = 5'd4; aluData = 32'h44;
    #1;
    chk("arb_memReady", memReady, 1'b1);
    chk("arb_aluReady", aluReady, 1'b0);
    step();
    memValid = 1'b0;
    #1;
    chk("arb_first_rd", rfRd, 5'd3);
    chk("arb_alu_ready", aluReady, 1'b1);
    step();
    aluValid = 1'b0;
    #1 chk("arb_second_rd", rfRd, 5'd4);
    step();

    // x0 writes are acknowledged but never queued
    memValid = 1'b1; memRd = 5'd0; memData = 32'h1234;
    #1 chk("x0_memReady", memReady, 1'b1);
    step();
    memValid = 1'b0;
    #1;
    chk("x0_count", count, 3'd0);
    chk("x0_we", rfWriteEnable, 1'b0);
    step();

    // Streaming twelve writes wraps the pointers three times
    write_log.delete();
    for (int i = 1; i <= 12; i++) begin
      aluValid = 1'b1; aluRd = 5'(i); aluData = 32'(i * 256);
      step();
      #1;
      chk("stream_count", count, 3'd1);
      chk("stream_full", full, 1'b0);
    end
    aluValid = 1'b0;
    step(); step();
    chk("stream_writes", write_log.size(), 12);
    for (int i = 0; i < 12 && i < write_log.size(); i++) begin
      chk("stream_order", write_log[i], 5'(i + 1));
    end

    // Youngest bypass for a repeated destination
    aluValid = 1'b1; aluRd = 5'd7; aluData = 32'h11; rs2 = 5'd7;
    step();
    aluData = 32'h22;
    #1 chk("young_first", rs2Fwd, 32'h11);
    step();
    aluValid = 1'b0;
    #1;
    chk("young_second", rs2Fwd, 32'h22);
    chk("young_hit", rs2Hit, 1'b1);
    step();

    // Reset mid-operation dominates a concurrent request
    aluValid = 1'b1; aluRd = 5'd9; aluData = 32'h99;
    step();
    rst = 1'b1; aluRd = 5'd10; aluData = 32'hAA;
    #1;
    chk("mid_rst_we", rfWriteEnable, 1'b0);
    chk("mid_rst_aluReady", aluReady, 1'b0);
    chk("mid_rst_memReady", memReady, 1'b0);
    step();
    rst = 1'b0; aluValid = 1'b0;
    #1;
    chk("post_rst_count", count, 3'd0);
    chk("post_rst_we", rfWriteEnable, 1'b0);
    chk("post_rst_memReady", memReady, 1'b1);
    chk("post_rst_aluReady", aluReady, 1'b1);
    step();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 39) == 0);
      memValid = $urandom_range(0, 2) == 0;
      aluValid = $urandom_range(0, 1) == 1;
      memRd    = 5'($urandom_range(0, 7));
      aluRd    = 5'($urandom_range(0, 7));
      memData  = $urandom;
      aluData  = $urandom;
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
